// File: rtl/alu_issue_ctrl.sv
// Sequencing front-end for the 32-bit ALU: decode, operand steering, shift-add MULT.
// Optional illegal-op trap enabled by defining ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_ctrl #(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      imm16,
    output logic [WIDTH-1:0] alu_value1,
    output logic [WIDTH-1:0] alu_value2,
    output logic [2:0]       alu_select,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_MUL, S_DONE} state_t;

    localparam logic [2:0] SEL_AND = 3'd0;
    localparam logic [2:0] SEL_ADD = 3'd1;
    localparam logic [2:0] SEL_SUB = 3'd2;
    localparam logic [2:0] SEL_XOR = 3'd3;
    localparam logic [2:0] SEL_NOR = 3'd4;
    localparam logic [2:0] SEL_OR  = 3'd5;
    localparam logic [2:0] SEL_SLT = 3'd6;
    localparam logic [5:0] STEPS   = 6'(MUL_STEPS);

    function automatic logic [2:0] dec_sel(input logic [5:0] op, input logic [5:0] fn);
        dec_sel = SEL_ADD;
        if (op == 6'h00) begin
            case (fn)
                6'h22:   dec_sel = SEL_SUB;
                6'h24:   dec_sel = SEL_AND;
                6'h25:   dec_sel = SEL_OR;
                6'h26:   dec_sel = SEL_XOR;
                6'h27:   dec_sel = SEL_NOR;
                6'h2A:   dec_sel = SEL_SLT;
                default: dec_sel = SEL_ADD;
            endcase
        end else begin
            case (op)
                6'h0A:        dec_sel = SEL_SLT;
                6'h0C:        dec_sel = SEL_AND;
                6'h0D:        dec_sel = SEL_OR;
                6'h0E:        dec_sel = SEL_XOR;
                6'h04, 6'h05: dec_sel = SEL_SUB;
                default:      dec_sel = SEL_ADD;
            endcase
        end
    endfunction

    // Second operand source: 0 = rt, 1 = sign-extended imm, 2 = zero-extended imm
    function automatic logic [1:0] dec_src(input logic [5:0] op);
        case (op)
            6'h08, 6'h0A, 6'h23, 6'h2B: dec_src = 2'd1;
            6'h0C, 6'h0D, 6'h0E:        dec_src = 2'd2;
            default:                    dec_src = 2'd0;
        endcase
    endfunction

    function automatic logic is_mult(input logic [5:0] op, input logic [5:0] fn);
        is_mult = (op == 6'h00) && (fn == 6'h18);
    endfunction

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h22, 6'h24, 6'h25,
                6'h26, 6'h27, 6'h2A, 6'h18: is_legal = 1'b1;
                default:                    is_legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                6'h23, 6'h2B, 6'h04, 6'h05: is_legal = 1'b1;
                default:                    is_legal = 1'b0;
            endcase
        end
    endfunction
`endif

    state_t             state_q, state_d;
    logic [5:0]         op_q, fn_q;
    logic [WIDTH-1:0]   rs_q, rt_q;
    logic [15:0]        imm_q;
    logic [WIDTH-1:0]   acc_q, mcand_q, mplier_q;
    logic [5:0]         cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic [WIDTH-1:0]   v1_q, v2_q, v1_d, v2_d;
    logic [2:0]         sel_q, sel_d;
    logic               accept;

    assign accept = (state_q == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        sel_d   = sel_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mult(opcode, funct)) state_d = S_MUL;
                    else                        state_d = S_ISSUE;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                    if (!is_legal(opcode, funct)) state_d = S_DONE;
`endif
                end
            end
            S_ISSUE: begin
                v1_d  = rs_q;
                sel_d = dec_sel(op_q, fn_q);
                case (dec_src(op_q))
                    2'd1:    v2_d = {{(WIDTH-16){imm_q[15]}}, imm_q};
                    2'd2:    v2_d = {{(WIDTH-16){1'b0}}, imm_q};
                    default: v2_d = rt_q;
                endcase
                state_d = S_DONE;
            end
            S_MUL: begin
                if (cnt_q == STEPS) begin
                    state_d = S_DONE;
                end else begin
                    v1_d  = acc_q;
                    v2_d  = mplier_q[0] ? mcand_q : '0;
                    sel_d = SEL_ADD;
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    // ALU-facing registers track what was last driven so idle cycles hold it
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= '0;
            v2_q  <= '0;
            sel_q <= SEL_ADD;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            sel_q <= sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            fn_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            if (accept) begin
                op_q     <= opcode;
                fn_q     <= funct;
                rs_q     <= rs_val;
                rt_q     <= rt_val;
                imm_q    <= imm16;
                acc_q    <= '0;
                mcand_q  <= rs_val;
                mplier_q <= rt_val;
                cnt_q    <= '0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                if (!is_legal(opcode, funct)) begin
                    result_q <= '0;
                    zero_q   <= 1'b1;
                end
`endif
            end
            if (state_q == S_ISSUE) begin
                result_q <= alu_result;
                zero_q   <= (alu_result == '0);
            end
            if (state_q == S_MUL) begin
                if (cnt_q == STEPS) begin
                    result_q <= acc_q;
                    zero_q   <= (acc_q == '0);
                end else begin
                    acc_q    <= alu_result;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 6'd1;
                end
            end
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk) begin
        if (reset)       illegal_q <= 1'b0;
        else if (accept) illegal_q <= !is_legal(opcode, funct);
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign alu_value1 = v1_d;
    assign alu_value2 = v2_d;
    assign alu_select = sel_d;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign result     = result_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomised self-checking bench for alu_issue_ctrl with a behavioural ALU and op model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [5:0]  opcode, funct;
    logic [31:0] rs_val, rt_val;
    logic [15:0] imm16;
    logic [31:0] alu_value1, alu_value2, alu_result, result;
    logic [2:0]  alu_select;
    logic        busy, done, zero, illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .opcode(opcode), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16),
        .alu_value1(alu_value1), .alu_value2(alu_value2),
        .alu_select(alu_select), .alu_result(alu_result),
        .busy(busy), .done(done), .result(result),
        .zero(zero), .illegal(illegal)
    );

    always_comb begin
        alu_result = 32'h0;
        case (alu_select)
            3'd0: alu_result = alu_value1 & alu_value2;
            3'd1: alu_result = alu_value1 + alu_value2;
            3'd2: alu_result = alu_value1 - alu_value2;
            3'd3: alu_result = alu_value1 ^ alu_value2;
            3'd4: alu_result = ~(alu_value1 | alu_value2);
            3'd5: alu_result = alu_value1 | alu_value2;
            3'd6: alu_result = {31'h0, $signed(alu_value1) < $signed(alu_value2)};
            default: alu_result = 32'h0;
        endcase
    end

    function automatic logic [31:0] ref_res(input logic [5:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [15:0] imm);
        logic [31:0] se, ze;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0, imm};
        if (op == 6'h00) begin
            case (fn)
                6'h20: return a + b;
                6'h22: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h26: return a ^ b;
                6'h27: return ~(a | b);
                6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h18: return a * b;
                default: return a + b;
            endcase
        end
        case (op)
            6'h08, 6'h23, 6'h2B: return a + se;
            6'h0A: return ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
            6'h0C: return a & ze;
            6'h0D: return a | ze;
            6'h0E: return a ^ ze;
            6'h04, 6'h05: return a - b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [2:0] ref_sel(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h22: return 3'd2;
                6'h24: return 3'd0;
                6'h25: return 3'd5;
                6'h26: return 3'd3;
                6'h27: return 3'd4;
                6'h2A: return 3'd6;
                default: return 3'd1;
            endcase
        end
        case (op)
            6'h0A: return 3'd6;
            6'h0C: return 3'd0;
            6'h0D: return 3'd5;
            6'h0E: return 3'd3;
            6'h04, 6'h05: return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic ref_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00)
            return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h18};
        return op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05};
    endfunction

    task automatic do_op(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input string name);
        logic [31:0] exp;
        logic        trap, mul;
        int          k, lat;
        exp = ref_res(op, fn, a, b, imm);
        mul = (op == 6'h00) && (fn == 6'h18);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        trap = !ref_legal(op, fn);
`else
        trap = 1'b0;
`endif
        if (trap) exp = 32'h0;
        lat = trap ? 0 : (mul ? 33 : 1);
        @(negedge clk);
        opcode = op; funct = fn; rs_val = a; rt_val = b; imm16 = imm;
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        opcode = 6'($urandom); funct = 6'($urandom);
        rs_val = $urandom; rt_val = $urandom; imm16 = 16'($urandom);
        if (!trap && !mul) begin
            checks++;
            if (alu_select !== ref_sel(op, fn) || alu_value1 !== a)
                $display("FAIL %s issue: sel=%0d v1=%h want sel=%0d v1=%h",
                         name, alu_select, alu_value1, ref_sel(op, fn), a);
            if (alu_select !== ref_sel(op, fn) || alu_value1 !== a) errors++;
        end
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d cycles", name, done, k);
        end
        checks++;
        if (k != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, k, lat);
        end
        checks++;
        if (result !== exp || zero !== (exp == 32'h0) || illegal !== trap) begin
            errors++;
            $display("FAIL %s result: res=%h z=%b ill=%b want res=%h z=%b ill=%b",
                     name, result, zero, illegal, exp, exp == 32'h0, trap);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b want 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        opcode = 6'h0; funct = 6'h20; rs_val = 32'h0; rt_val = 32'h0; imm16 = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result !== 32'h0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            illegal !== 1'b0 || alu_select !== 3'd1 ||
            alu_value1 !== 32'h0 || alu_value2 !== 32'h0) begin
            errors++;
            $display("FAIL reset: res=%h z=%b busy=%b done=%b ill=%b sel=%0d v1=%h v2=%h",
                     result, zero, busy, done, illegal, alu_select, alu_value1, alu_value2);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        bit seen;
        do_op(6'h00, 6'h20, 32'h1234, 32'h1, 16'h0, "pre_reset_add");
        @(negedge clk);
        opcode = 6'h00; funct = 6'h18; rs_val = 32'h3; rt_val = 32'h7;
        start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || zero !== 1'b1 ||
            alu_select !== 3'd1) begin
            errors++;
            $display("FAIL reset_mid_mul: busy=%b done=%b res=%h z=%b sel=%0d want 0 0 0 1 1",
                     busy, done, result, zero, alu_select);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_mul_nodone: done pulsed=%b want 0", seen);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn;
        do_op(6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 16'h0, "add_wrap");
        do_op(6'h00, 6'h22, 32'h5, 32'h5, 16'h0, "sub_zero");
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 6))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                4: fn = 6'h26;
                5: fn = 6'h27;
                default: fn = 6'h2A;
            endcase
            do_op(6'h00, fn, $urandom, $urandom, 16'($urandom), "rtype_rand");
        end
    endtask

    task automatic test_itype();
        logic [5:0] op;
        do_op(6'h08, 6'h00, 32'h10, 32'h0, 16'hFFFF, "addi_sext");
        do_op(6'h0D, 6'h00, 32'h0, 32'h0, 16'h8000, "ori_zext");
        do_op(6'h0A, 6'h00, 32'hFFFFFFFE, 32'h0, 16'h0001, "slti_signed");
        do_op(6'h04, 6'h00, 32'h55, 32'h55, 16'h1234, "beq_sub");
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 8))
                0: op = 6'h08;
                1: op = 6'h0A;
                2: op = 6'h0C;
                3: op = 6'h0D;
                4: op = 6'h0E;
                5: op = 6'h23;
                6: op = 6'h2B;
                7: op = 6'h04;
                default: op = 6'h05;
            endcase
            do_op(op, 6'($urandom), $urandom, $urandom, 16'($urandom), "itype_rand");
        end
    endtask

    task automatic test_mult();
        do_op(6'h00, 6'h18, 32'h00010003, 32'h5, 16'h0, "mult_basic");
        do_op(6'h00, 6'h18, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0, "mult_neg1");
        do_op(6'h00, 6'h18, 32'h0, 32'h1234, 16'h0, "mult_zero");
        for (int i = 0; i < 3; i++)
            do_op(6'h00, 6'h18, $urandom, $urandom, 16'h0, "mult_rand");
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ops_fn [3];
        logic [5:0]  h_op [9];
        logic [5:0]  h_fn [9];
        logic [31:0] h_a [9];
        logic [31:0] h_b [9];
        logic [31:0] exp;
        ops_fn[0] = 6'h24; ops_fn[1] = 6'h27; ops_fn[2] = 6'h2A;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start = 1'b1;
            if (i % 3 == 0) begin
                opcode = 6'h00; funct = ops_fn[i/3];
            end else begin
                opcode = 6'($urandom); funct = 6'($urandom);
            end
            rs_val = $urandom; rt_val = $urandom; imm16 = 16'($urandom);
            h_op[i] = opcode; h_fn[i] = funct; h_a[i] = rs_val; h_b[i] = rt_val;
            @(posedge clk); #1;
            checks++;
            if (done !== (i % 3 == 1)) begin
                errors++;
                $display("FAIL b2b_done cycle %0d: done=%b want %b", i, done, i % 3 == 1);
            end
            if (i % 3 == 1) begin
                exp = ref_res(h_op[i-1], h_fn[i-1], h_a[i-1], h_b[i-1], 16'h0);
                checks++;
                if (result !== exp) begin
                    errors++;
                    $display("FAIL b2b_result cycle %0d: res=%h want %h", i, result, exp);
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        do_op(6'h00, 6'h3F, 32'h100, 32'h23, 16'h0, "illegal_funct");
        do_op(6'h00, 6'h20, 32'h1, 32'h2, 16'h0, "after_illegal");
        do_op(6'h3F, 6'h00, 32'h0, 32'h0, 16'h7, "illegal_opcode");
        do_op(6'h0D, 6'h00, 32'h0, 32'h0, 16'h0, "legal_zero");
    endtask

    initial begin
        test_reset();
        test_reset_mid_mul();
        test_rtype();
        test_itype();
        test_mult();
        test_back_to_back();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
